// File: rtl/segment_pkg.sv
// Shared definitions for the seven-segment reader: segment patterns, bus bit
// positions, reader state encoding and a BCD value helper.
package segment_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;

    localparam int SEG_DIG_BIT = 8;
    localparam int SEG_DP_BIT  = 7;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } reader_state_e;

    // Two BCD digits folded into their 0..99 value.
    function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] units);
        return (7'(tens) * 7'd10) + 7'(units);
    endfunction

endpackage

// File: rtl/segment_reader_if.sv
// Bus bundle between the segment display source / reading consumer (master)
// and the segment_reader (slave).
interface segment_reader_if;

    logic [8:0] seg_led_1;
    logic [8:0] seg_led_2;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic       out_valid;
    logic       out_ready;
    logic       err_pattern;
    logic       err_overrun;
    logic       err_step;

    modport master (
        output seg_led_1, seg_led_2, out_ready,
        input  digit_1, digit_2, out_valid, err_pattern, err_overrun, err_step
    );

    modport slave (
        input  seg_led_1, seg_led_2, out_ready,
        output digit_1, digit_2, out_valid, err_pattern, err_overrun, err_step
    );

endinterface

// File: rtl/segment_decode.sv
// Combinational decode of one 9-bit segment bus into a BCD digit plus
// legal/blank flags; the decimal point is ignored.
module segment_decode
    import segment_pkg::*;
(
    input  logic [8:0] pattern,
    output logic [3:0] digit,
    output logic       legal,
    output logic       blank
);

    logic unused_dp_s;
    assign unused_dp_s = pattern[SEG_DP_BIT];

    // Pattern lookup; anything outside the ten glyphs is illegal.
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        blank = pattern[SEG_DIG_BIT];
        case (pattern[6:0])
            SEG_PAT_0: digit = 4'd0;
            SEG_PAT_1: digit = 4'd1;
            SEG_PAT_2: digit = 4'd2;
            SEG_PAT_3: digit = 4'd3;
            SEG_PAT_4: digit = 4'd4;
            SEG_PAT_5: digit = 4'd5;
            SEG_PAT_6: digit = 4'd6;
            SEG_PAT_7: digit = 4'd7;
            SEG_PAT_8: digit = 4'd8;
            SEG_PAT_9: digit = 4'd9;
            default: begin
                digit = 4'd0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/segment_reader.sv
// segment_reader: synchronizes, debounces and decodes the two-digit segment
// buses into a valid/ready BCD stream. Macro SEGMENT_READER_STEP_CHECK_EN adds
// counting-sequence checking on err_step.
module segment_reader
    import segment_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    segment_reader_if.slave bus
);

    localparam logic [7:0]  CNT_MAX   = 8'(STABLE_CYCLES);
    localparam logic [17:0] LAST_INIT = 18'h3FFFF;

    logic [17:0]   sync1_r, sync2_r, samp_r, last_r, last_nx_s;
    logic [7:0]    cnt_r;
    logic [3:0]    dec1_digit_s, dec2_digit_s;
    logic          dec1_legal_s, dec2_legal_s, dec1_blank_s, dec2_blank_s;
    logic          commit_s, legal_commit_s;
    logic [3:0]    digit_1_r, digit_2_r, digit_1_nx_s, digit_2_nx_s;
    logic          out_valid_r, out_valid_nx_s;
    logic          err_pattern_r, err_pattern_nx_s;
    logic          err_overrun_r, err_overrun_nx_s;
    reader_state_e state_r, state_nx_s;

    // Synchronizer, previous-sample register and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 18'h00000;
            sync2_r <= 18'h00000;
            samp_r  <= 18'h00000;
            cnt_r   <= 8'd0;
        end else begin
            sync1_r <= {bus.seg_led_1, bus.seg_led_2};
            sync2_r <= sync1_r;
            samp_r  <= sync2_r;
            if (sync2_r != samp_r) begin
                cnt_r <= 8'd1;
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    segment_decode u_dec_1 (
        .pattern (samp_r[17:9]),
        .digit   (dec1_digit_s),
        .legal   (dec1_legal_s),
        .blank   (dec1_blank_s)
    );

    segment_decode u_dec_2 (
        .pattern (samp_r[8:0]),
        .digit   (dec2_digit_s),
        .legal   (dec2_legal_s),
        .blank   (dec2_blank_s)
    );

    // samp_r is the pair that has been stable for CNT_MAX samples.
    assign commit_s       = (cnt_r == CNT_MAX) && (samp_r != last_r);
    assign legal_commit_s = commit_s && !dec1_blank_s && !dec2_blank_s
                            && dec1_legal_s && dec2_legal_s;

    // Reader state transitions.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (legal_commit_s) begin
                    state_nx_s = ST_TRACK;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_TRACK: state_nx_s = ST_TRACK;
            default:  state_nx_s = ST_EMPTY;
        endcase
    end

    // Commit handling, handshake and error pulses.
    always_comb begin
        last_nx_s        = last_r;
        digit_1_nx_s     = digit_1_r;
        digit_2_nx_s     = digit_2_r;
        err_pattern_nx_s = 1'b0;
        err_overrun_nx_s = 1'b0;
        if (out_valid_r && bus.out_ready) begin
            out_valid_nx_s = 1'b0;
        end else begin
            out_valid_nx_s = out_valid_r;
        end
        if (commit_s) begin
            last_nx_s = samp_r;
            if (dec1_blank_s || dec2_blank_s) begin
                err_pattern_nx_s = 1'b0;
            end else if (dec1_legal_s && dec2_legal_s) begin
                digit_1_nx_s     = dec1_digit_s;
                digit_2_nx_s     = dec2_digit_s;
                out_valid_nx_s   = 1'b1;
                err_overrun_nx_s = out_valid_r && !bus.out_ready;
            end else begin
                err_pattern_nx_s = 1'b1;
            end
        end else begin
            last_nx_s = last_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_EMPTY;
            last_r        <= LAST_INIT;
            digit_1_r     <= 4'd0;
            digit_2_r     <= 4'd0;
            out_valid_r   <= 1'b0;
            err_pattern_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            last_r        <= last_nx_s;
            digit_1_r     <= digit_1_nx_s;
            digit_2_r     <= digit_2_nx_s;
            out_valid_r   <= out_valid_nx_s;
            err_pattern_r <= err_pattern_nx_s;
            err_overrun_r <= err_overrun_nx_s;
        end
    end

    assign bus.digit_1     = digit_1_r;
    assign bus.digit_2     = digit_2_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.err_pattern = err_pattern_r;
    assign bus.err_overrun = err_overrun_r;

`ifdef SEGMENT_READER_STEP_CHECK_EN
    logic [6:0] prev_r, prev_nx_s, value_s, succ_s;
    logic       err_step_r, err_step_nx_s;

    // A zero reading is always accepted: the counter may wrap early.
    always_comb begin
        value_s       = bcd_value(dec1_digit_s, dec2_digit_s);
        succ_s        = (prev_r == 7'd99) ? 7'd0 : (prev_r + 7'd1);
        prev_nx_s     = prev_r;
        err_step_nx_s = 1'b0;
        if (legal_commit_s) begin
            prev_nx_s     = value_s;
            err_step_nx_s = (state_r == ST_TRACK) && (value_s != succ_s)
                            && (value_s != 7'd0);
        end else begin
            prev_nx_s = prev_r;
        end
    end

    // Previous legal value and step error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r     <= 7'd0;
            err_step_r <= 1'b0;
        end else begin
            prev_r     <= prev_nx_s;
            err_step_r <= err_step_nx_s;
        end
    end

    assign bus.err_step = err_step_r;
`else
    assign bus.err_step = 1'b0;
`endif

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed scenarios followed by
// randomized segment pairs, checked against a reading-level reference model.
module tb_segment_reader;

    localparam int S = 4;
    localparam int H = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_pat = 0, n_ovr = 0, n_step = 0;

    int pats [10] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66,
                      32'h6D, 32'h7D, 32'h07, 32'h7F, 32'h6F};

    // Reference model state, expressed in readings rather than registers.
    logic [17:0] m_last;
    logic        m_valid;
    int          m_d1, m_d2, m_prev;
    bit          m_track;
    int          e_pat, e_ovr, e_step;

    segment_reader_if bus_if ();

    segment_reader #(.STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.err_pattern) n_pat++;
        if (bus_if.err_overrun) n_ovr++;
        if (bus_if.err_step)    n_step++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pat2dig(input logic [8:0] p);
        for (int i = 0; i < 10; i++) begin
            if (p[6:0] == 7'(pats[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [8:0] enc(input int d, input logic dp);
        logic [6:0] p7;
        p7 = 7'(pats[d]);
        return {1'b0, dp, p7};
    endfunction

    function automatic void model_reset();
        m_last  = 18'h3FFFF;
        m_valid = 1'b0;
        m_d1    = 0;
        m_d2    = 0;
        m_prev  = 0;
        m_track = 1'b0;
    endfunction

    // Outcome of holding pair (a,b) long enough with out_ready = r.
    function automatic void model_apply(input logic [8:0] a, input logic [8:0] b, input logic r);
        int da, db, v;
        e_pat = 0; e_ovr = 0; e_step = 0;
        if (r) m_valid = 1'b0;
        if ({a, b} != m_last) begin
            m_last = {a, b};
            if (!a[8] && !b[8]) begin
                da = pat2dig(a);
                db = pat2dig(b);
                if (da < 0 || db < 0) begin
                    e_pat = 1;
                end else begin
                    v = da * 10 + db;
                    if (m_valid && !r) e_ovr = 1;
                    if (!r) m_valid = 1'b1;
                    m_d1 = da;
                    m_d2 = db;
`ifdef SEGMENT_READER_STEP_CHECK_EN
                    if (m_track && !(v == (m_prev + 1) % 100 || v == 0)) e_step = 1;
`endif
                    m_prev  = v;
                    m_track = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_window(input string tag);
        check({tag, " digit_1"},     32'(bus_if.digit_1),   32'(m_d1));
        check({tag, " digit_2"},     32'(bus_if.digit_2),   32'(m_d2));
        check({tag, " out_valid"},   32'(bus_if.out_valid), 32'(m_valid));
        check({tag, " err_pattern"}, 32'(n_pat),  32'(e_pat));
        check({tag, " err_overrun"}, 32'(n_ovr),  32'(e_ovr));
        check({tag, " err_step"},    32'(n_step), 32'(e_step));
    endtask

    task automatic run_window(input string tag, input logic [8:0] a, input logic [8:0] b, input logic r);
        bus_if.seg_led_1 = a;
        bus_if.seg_led_2 = b;
        bus_if.out_ready = r;
        model_apply(a, b, r);
        n_pat = 0; n_ovr = 0; n_step = 0;
        repeat (H) tick();
        check_window(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [8:0] a, b;
        logic       r;
        int         sel, v;

        bus_if.seg_led_1 = 9'h1FF;
        bus_if.seg_led_2 = 9'h1FF;
        bus_if.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        check("reset digit_1",     32'(bus_if.digit_1),     32'd0);
        check("reset digit_2",     32'(bus_if.digit_2),     32'd0);
        check("reset out_valid",   32'(bus_if.out_valid),   32'd0);
        check("reset err_pattern", 32'(bus_if.err_pattern), 32'd0);
        check("reset err_overrun", 32'(bus_if.err_overrun), 32'd0);
        check("reset err_step",    32'(bus_if.err_step),    32'd0);
        repeat (8) tick();

        // Latency: valid appears after edge N+2+S and lasts one cycle.
        bus_if.seg_led_1 = 9'h03F;
        bus_if.seg_led_2 = 9'h006;
        model_apply(9'h03F, 9'h006, 1'b1);
        n_pat = 0; n_ovr = 0; n_step = 0;
        repeat (S + 2) tick();
        check("latency early valid", 32'(bus_if.out_valid), 32'd0);
        tick();
        check("latency valid",   32'(bus_if.out_valid), 32'd1);
        check("latency digit_1", 32'(bus_if.digit_1),   32'd0);
        check("latency digit_2", 32'(bus_if.digit_2),   32'd1);
        tick();
        check("latency valid drop", 32'(bus_if.out_valid), 32'd0);
        repeat (4) tick();
        check_window("latency");

        // Short glitch does not commit.
        bus_if.seg_led_1 = 9'h07F;
        bus_if.seg_led_2 = 9'h07F;
        repeat (2) tick();
        run_window("glitch", 9'h03F, 9'h006, 1'b1);

        // Overrun, then acceptance.
        run_window("ovr 34", 9'h04F, 9'h066, 1'b0);
        run_window("ovr 35", 9'h04F, 9'h06D, 1'b0);
        run_window("ovr accept", 9'h04F, 9'h06D, 1'b1);

        run_window("illegal", 9'h04F, 9'h049, 1'b1);

        // Counting sequence 08 09 10 12 00.
        do_reset();
        run_window("seq 08", enc(0, 1'b0), enc(8, 1'b0), 1'b1);
        run_window("seq 09", enc(0, 1'b0), enc(9, 1'b0), 1'b1);
        run_window("seq 10", enc(1, 1'b0), enc(0, 1'b0), 1'b1);
        run_window("seq 12", enc(1, 1'b0), enc(2, 1'b0), 1'b1);
        run_window("seq 00", enc(0, 1'b0), enc(0, 1'b0), 1'b1);

        // Reset while a reading is pending.
        run_window("pre-reset", 9'h04F, 9'h066, 1'b0);
        rst = 1'b1;
        tick();
        check("midreset out_valid", 32'(bus_if.out_valid), 32'd0);
        check("midreset digit_1",   32'(bus_if.digit_1),   32'd0);
        check("midreset digit_2",   32'(bus_if.digit_2),   32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        run_window("post-reset", 9'h04F, 9'h066, 1'b0);

        // Randomized pairs.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 9));
            r   = 1'($urandom_range(0, 1));
            v   = int'($urandom_range(0, 99));
            if (sel >= 3 && sel <= 5) v = (m_prev + 1) % 100;
            a = enc(v / 10, 1'($urandom_range(0, 1)));
            b = enc(v % 10, 1'($urandom_range(0, 1)));
            if (sel == 0) begin
                if ($urandom_range(0, 1) == 0) a = 9'h049;
                else                           b = 9'h011;
            end else if (sel == 1) begin
                a = {1'b1, 8'($urandom_range(0, 255))};
            end else if (sel == 2) begin
                a = bus_if.seg_led_1;
                b = bus_if.seg_led_2;
            end else begin
                a = a;
            end
            run_window("random", a, b, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
